// File: rtl/pixel_array_ctrl_if.sv
// ----------------------------------------------------------------------------
// pixel_array_ctrl_if
//
// Control strobes from the frame controller to the 4-pixel array.
//   ERASE    1  pixel erase control
//   EXPOSE   1  pixel expose control
//   CONVERT  1  pixel convert control (pixels latch DATA while this is high)
//   READ     4  one-hot read select, READ[0] = pixel 1 ... READ[3] = pixel 4
//
// Handshake: these are plain level controls with no valid/ready pairing.
// The controller is the only master. A pixel acts on whichever control
// is high in a given cycle, and at most one control is high at a time.
// The shared 8-bit DATA bus is a tristate net. It stays a plain inout
// port on the controller so that every driver resolves on a single wire.
// ----------------------------------------------------------------------------
interface pixel_array_ctrl_if;
    logic       ERASE;
    logic       EXPOSE;
    logic       CONVERT;
    logic [3:0] READ;

    modport master (output ERASE, output EXPOSE, output CONVERT, output READ);
    modport slave  (input  ERASE, input  EXPOSE, input  CONVERT, input  READ);
endinterface

// File: rtl/pixel_array_ctrl.sv
// ----------------------------------------------------------------------------
// pixel_array_ctrl
//
// Frame controller and readout engine for a 4-pixel sensor array. Each frame
// runs ERASE, EXPOSE, CONVERT, a one-cycle bus turnaround, and then
// READ1..READ4. During CONVERT the controller drives a ramp code on DATA, and
// each pixel latches that code. During READ the controller releases DATA and
// samples each pixel in turn.
//
// Ports
//   CLK          in   system clock, rising edge
//   RESET        in   asynchronous active-high reset
//   START        in   request one frame (only looked at in IDLE)
//   CONTINUOUS   in   sampled in the last READ4 cycle; 1 = chain next frame
//   pix          if   ERASE / EXPOSE / CONVERT / READ[3:0] controls (master)
//   DATA         io   shared pixel bus, driven only in CONVERT
//   PIXEL_DATA   out  last sampled pixel code
//   PIXEL_IDX    out  index of the pixel held in PIXEL_DATA
//   PIXEL_VALID  out  one-cycle pulse when PIXEL_DATA/PIXEL_IDX are new
//   FRAME_DONE   out  one-cycle pulse together with the 4th PIXEL_VALID
//   BUSY         out  high in every state except IDLE
//   DBG_STATE    out  current FSM state encoding
//
// Handshake: the pixel output is valid-only. PIXEL_VALID qualifies
// PIXEL_DATA and PIXEL_IDX for exactly one cycle. There is no ready input,
// so the consumer must take the value in that cycle. The data and index
// hold until the next capture.
//
// CONVERT_CYCLES must be in 1..256 so the 8-bit ramp never wraps.
// READ_CYCLES must be at least 2 so the pixel has settled on the bus
// before the sample is taken.
// ----------------------------------------------------------------------------
module pixel_array_ctrl #(
    parameter int ERASE_CYCLES   = 5,
    parameter int EXPOSE_CYCLES  = 255,
    parameter int CONVERT_CYCLES = 255,
    parameter int READ_CYCLES    = 5
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      START,
    input  logic                      CONTINUOUS,
    pixel_array_ctrl_if.master        pix,
    inout  wire  [7:0]                DATA,
    output logic [7:0]                PIXEL_DATA,
    output logic [1:0]                PIXEL_IDX,
    output logic                      PIXEL_VALID,
    output logic                      FRAME_DONE,
    output logic                      BUSY,
    output logic [2:0]                DBG_STATE
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ERASE   = 3'd1,
        S_EXPOSE  = 3'd2,
        S_CONVERT = 3'd3,
        S_TURN    = 3'd4,
        S_READ    = 3'd5
    } state_t;

    // Terminal counts: a phase lasts while cnt_q runs from 0 to *_LAST.
    localparam logic [15:0] ERASE_LAST   = 16'(ERASE_CYCLES - 1);
    localparam logic [15:0] EXPOSE_LAST  = 16'(EXPOSE_CYCLES - 1);
    localparam logic [15:0] CONVERT_LAST = 16'(CONVERT_CYCLES - 1);
    localparam logic [15:0] READ_LAST    = 16'(READ_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  pdata_q, pdata_d;
    logic [1:0]  pidx_q, pidx_d;
    logic        valid_q, valid_d;
    logic        done_q, done_d;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            pdata_q <= '0;
            pidx_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            pdata_q <= pdata_d;
            pidx_q  <= pidx_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        pdata_d = pdata_q;
        pidx_d  = pidx_q;
        valid_d = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d = S_ERASE;
                    cnt_d   = '0;
                end
            end
            S_ERASE: begin
                if (cnt_q == ERASE_LAST) begin
                    state_d = S_EXPOSE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_EXPOSE: begin
                if (cnt_q == EXPOSE_LAST) begin
                    state_d = S_CONVERT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_CONVERT: begin
                if (cnt_q == CONVERT_LAST) begin
                    state_d = S_TURN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_TURN: begin
                // One dead cycle so that the controller's bus driver is off
                // before any pixel starts to drive.
                state_d = S_READ;
                cnt_d   = '0;
                idx_d   = '0;
            end
            S_READ: begin
                if (cnt_q == READ_LAST) begin
                    // Sample in the last cycle of the window. DATA is taken
                    // as-is, including an undriven bus.
                    cnt_d   = '0;
                    pdata_d = DATA;
                    pidx_d  = idx_q;
                    valid_d = 1'b1;
                    if (idx_q == 2'd3) begin
                        done_d  = 1'b1;
                        idx_d   = '0;
                        state_d = CONTINUOUS ? S_ERASE : S_IDLE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Controls decode straight from state_q. An asynchronous reset therefore
    // drops every control and releases DATA without waiting for a clock.
    assign pix.ERASE   = (state_q == S_ERASE);
    assign pix.EXPOSE  = (state_q == S_EXPOSE);
    assign pix.CONVERT = (state_q == S_CONVERT);
    assign pix.READ    = (state_q == S_READ) ? (4'b0001 << idx_q) : 4'b0000;

    assign DATA        = (state_q == S_CONVERT) ? cnt_q[7:0] : 8'bz;

    assign PIXEL_DATA  = pdata_q;
    assign PIXEL_IDX   = pidx_q;
    assign PIXEL_VALID = valid_q;
    assign FRAME_DONE  = done_q;
    assign BUSY        = (state_q != S_IDLE);
    assign DBG_STATE   = state_q;

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pixel_array_ctrl
//
// Directed bench with two controllers on a shared clock and reset.
//   u_a : default parameters
//   u_b : CONVERT_CYCLES = 256, READ_CYCLES = 2
//
// Each controller has four pixel models. A pixel latches DATA when the ramp
// equals its threshold. On its READ window it drives the inverted code for
// the first cycle (still settling) and the true code after that. Each DATA
// net has a pulldown, so a released bus reads as 0.
// ----------------------------------------------------------------------------
module tb_pixel_array_ctrl;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    logic START_A, CONT_A, START_B, CONT_B;

    pixel_array_ctrl_if a_if ();
    pixel_array_ctrl_if b_if ();

    wire  [7:0] DATA_A, DATA_B;
    logic [7:0] pdata_a, pdata_b;
    logic [1:0] pidx_a, pidx_b;
    logic       valid_a, valid_b, done_a, done_b, busy_a, busy_b;
    logic [2:0] state_a, state_b;

    pixel_array_ctrl u_a (
        .CLK(CLK), .RESET(RESET), .START(START_A), .CONTINUOUS(CONT_A),
        .pix(a_if), .DATA(DATA_A),
        .PIXEL_DATA(pdata_a), .PIXEL_IDX(pidx_a), .PIXEL_VALID(valid_a),
        .FRAME_DONE(done_a), .BUSY(busy_a), .DBG_STATE(state_a)
    );

    pixel_array_ctrl #(.CONVERT_CYCLES(256), .READ_CYCLES(2)) u_b (
        .CLK(CLK), .RESET(RESET), .START(START_B), .CONTINUOUS(CONT_B),
        .pix(b_if), .DATA(DATA_B),
        .PIXEL_DATA(pdata_b), .PIXEL_IDX(pidx_b), .PIXEL_VALID(valid_b),
        .FRAME_DONE(done_b), .BUSY(busy_b), .DBG_STATE(state_b)
    );

    pulldown pd_a (DATA_A);
    pulldown pd_b (DATA_B);

    // ---------------- pixel models ----------------
    logic [7:0] thr_a [4] = '{8'd0, 8'd76, 8'd178, 8'd254};
    logic [7:0] thr_b [4] = '{8'd255, 8'd1, 8'd128, 8'd0};
    logic [7:0] lat_a [4] = '{default: 8'h5A};
    logic [7:0] lat_b [4] = '{default: 8'h5A};
    logic [3:0] rdp_a = 4'd0;
    logic [3:0] rdp_b = 4'd0;

    always @(posedge CLK) begin
        rdp_a <= a_if.READ;
        rdp_b <= b_if.READ;
        for (int i = 0; i < 4; i++) begin
            if (a_if.CONVERT && DATA_A == thr_a[i]) lat_a[i] <= DATA_A;
            if (b_if.CONVERT && DATA_B == thr_b[i]) lat_b[i] <= DATA_B;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_pix
        assign DATA_A = a_if.READ[g] ? (rdp_a[g] ? lat_a[g] : ~lat_a[g]) : 8'bz;
        assign DATA_B = b_if.READ[g] ? (rdp_b[g] ? lat_b[g] : ~lat_b[g]) : 8'bz;
    end

    // ---------------- view of the selected DUT ----------------
    logic       sel;
    logic       v_erase, v_expose, v_convert, v_valid, v_done, v_busy;
    logic [3:0] v_read;
    logic [7:0] v_data, v_pdata;
    logic [1:0] v_pidx;
    logic [2:0] v_state;

    always_comb begin
        if (sel) begin
            v_erase = b_if.ERASE;   v_expose = b_if.EXPOSE; v_convert = b_if.CONVERT;
            v_read  = b_if.READ;    v_data   = DATA_B;      v_pdata   = pdata_b;
            v_pidx  = pidx_b;       v_valid  = valid_b;     v_done    = done_b;
            v_busy  = busy_b;       v_state  = state_b;
        end else begin
            v_erase = a_if.ERASE;   v_expose = a_if.EXPOSE; v_convert = a_if.CONVERT;
            v_read  = a_if.READ;    v_data   = DATA_A;      v_pdata   = pdata_a;
            v_pidx  = pidx_a;       v_valid  = valid_a;     v_done    = done_a;
            v_busy  = busy_a;       v_state  = state_a;
        end
    end

    // ---------------- scoreboard / stats ----------------
    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int erase_n, expose_n, conv_n, turn_n, conv_exp;
    int conv_err, bus_err, ovl_err, busy_err;
    int read_n [4];
    int first_erase, done_cyc, last_valid_cyc;
    logic done_busy, done_erase;
    logic [7:0] conv_last;
    logic [9:0] exp_q [$];
    logic [9:0] obs_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_stats();
        erase_n = 0; expose_n = 0; conv_n = 0; turn_n = 0; conv_exp = 0;
        conv_err = 0; bus_err = 0; ovl_err = 0; busy_err = 0;
        for (int i = 0; i < 4; i++) read_n[i] = 0;
        first_erase = -1; done_cyc = -1; last_valid_cyc = -1;
        done_busy = 1'b0; done_erase = 1'b0; conv_last = 8'd0;
        exp_q.delete(); obs_q.delete();
    endtask

    // One clock; observe #1 after the edge and fold into the stats.
    task automatic step();
        logic ctrl_any;
        @(posedge CLK);
        #1;
        cyc++;
        ctrl_any = v_erase || v_expose || v_convert || (v_read != 4'd0);
        if (v_erase) begin
            erase_n++;
            if (first_erase < 0) first_erase = cyc;
        end
        if (v_expose) expose_n++;
        if (v_convert) begin
            if (v_data !== 8'(conv_exp)) conv_err++;
            conv_exp++;
            conv_n++;
            conv_last = v_data;
        end else if (v_read == 4'd0 && v_data !== 8'd0) begin
            bus_err++;
        end
        if (v_busy && !ctrl_any) turn_n++;
        for (int i = 0; i < 4; i++) if (v_read[i]) read_n[i]++;
        if ((int'(v_erase) + int'(v_expose) + int'(v_convert) + $countones(v_read)) > 1) ovl_err++;
        if (ctrl_any && !v_busy) busy_err++;
        if (v_valid) begin
            obs_q.push_back({v_pidx, v_pdata});
            last_valid_cyc = cyc;
        end
        if (v_done) begin
            done_cyc   = cyc;
            done_busy  = v_busy;
            done_erase = v_erase;
        end
    endtask

    task automatic run_to_done(input int budget);
        int k;
        k = 0;
        while (done_cyc < 0 && k < budget) begin
            step();
            k++;
        end
        chk("frame_done_seen", 32'(done_cyc >= 0), 32'd1);
    endtask

    task automatic check_pixels();
        logic [9:0] e, o;
        int i;
        chk("pixel_count", obs_q.size(), exp_q.size());
        i = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 10'h3FF;
            chk($sformatf("pixel%0d_idx_data", i), 32'(o), 32'(e));
            i++;
        end
        obs_q.delete();
    endtask

    task automatic check_phases(input int conv_len, input int read_len);
        chk("expose_len", expose_n, 255);
        chk("convert_len", conv_n, conv_len);
        chk("convert_last_code", 32'(conv_last), 32'(conv_len - 1));
        chk("convert_ramp_err", conv_err, 0);
        chk("turn_len", turn_n, 1);
        for (int i = 0; i < 4; i++) chk($sformatf("read%0d_len", i), read_n[i], read_len);
        chk("bus_released", bus_err, 0);
        chk("ctrl_overlap", ovl_err, 0);
        chk("busy_with_ctrl", busy_err, 0);
        chk("last_valid_is_done", last_valid_cyc, done_cyc);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int prev_done;
        int k;
        sel = 1'b0;
        RESET = 1'b1;
        START_A = 1'b0; CONT_A = 1'b0; START_B = 1'b0; CONT_B = 1'b0;
        clear_stats();

        // Reset state
        step(); step();
        chk("rst_erase", v_erase, 0);
        chk("rst_expose", v_expose, 0);
        chk("rst_convert", v_convert, 0);
        chk("rst_read", v_read, 0);
        chk("rst_valid", v_valid, 0);
        chk("rst_done", v_done, 0);
        chk("rst_busy", v_busy, 0);
        chk("rst_pdata", v_pdata, 0);
        chk("rst_pidx", v_pidx, 0);
        chk("rst_state", v_state, 0);
        chk("rst_data_released", v_data, 0);
        RESET = 1'b0;
        step(); step(); step();
        chk("idle_busy", v_busy, 0);

        // Single frame, CONTINUOUS = 0
        clear_stats();
        exp_q.push_back({2'd0, 8'd0});   exp_q.push_back({2'd1, 8'd76});
        exp_q.push_back({2'd2, 8'd178}); exp_q.push_back({2'd3, 8'd254});
        START_A = 1'b1;
        step();
        START_A = 1'b0;
        chk("start_to_erase", v_erase, 1);
        run_to_done(700);
        chk("erase_len", erase_n, 5);
        check_phases(255, 5);
        chk("frame_len", done_cyc - first_erase, 536);
        chk("done_busy_low", done_busy, 0);
        check_pixels();
        step(); step(); step();
        chk("after_valid_low", v_valid, 0);
        chk("after_pdata_hold", v_pdata, 8'd254);
        chk("after_pidx_hold", v_pidx, 2'd3);
        chk("after_busy", v_busy, 0);

        // Back-to-back frames with START held high
        clear_stats();
        exp_q.push_back({2'd0, 8'd0});   exp_q.push_back({2'd1, 8'd76});
        exp_q.push_back({2'd2, 8'd178}); exp_q.push_back({2'd3, 8'd254});
        CONT_A = 1'b1;
        START_A = 1'b1;
        run_to_done(700);
        chk("cont_erase_incl_next", erase_n, 6);
        chk("cont_next_erase", done_erase, 1);
        chk("cont_done_busy", done_busy, 1);
        chk("cont_frame_len", done_cyc - first_erase, 536);
        check_pixels();

        // Second chained frame: mid-frame START pulse, then drop CONTINUOUS
        prev_done = done_cyc;
        clear_stats();
        first_erase = prev_done;
        erase_n = 1;
        exp_q.push_back({2'd0, 8'd0});   exp_q.push_back({2'd1, 8'd76});
        exp_q.push_back({2'd2, 8'd178}); exp_q.push_back({2'd3, 8'd254});
        START_A = 1'b0;
        for (int i = 0; i < 100; i++) step();
        START_A = 1'b1;
        step();
        START_A = 1'b0;
        CONT_A = 1'b0;
        run_to_done(700);
        chk("f2_frame_len", done_cyc - first_erase, 536);
        chk("f2_erase_len", erase_n, 5);
        chk("f2_to_idle", done_erase, 0);
        chk("f2_done_busy", done_busy, 0);
        check_pixels();
        for (int i = 0; i < 20; i++) step();
        chk("f2_no_queued_start", v_busy, 0);
        chk("f2_idle_state", v_state, 0);

        // Asynchronous reset at ramp code 100
        clear_stats();
        START_A = 1'b1;
        step();
        START_A = 1'b0;
        k = 0;
        while (!(v_convert && v_data == 8'd100) && k < 700) begin
            step();
            k++;
        end
        chk("reached_code_100", 32'(v_convert && v_data == 8'd100), 32'd1);
        #2;
        RESET = 1'b1;
        #1;
        chk("arst_convert", v_convert, 0);
        chk("arst_data_released", v_data, 0);
        chk("arst_read", v_read, 0);
        chk("arst_busy", v_busy, 0);
        chk("arst_state", v_state, 0);
        chk("arst_pdata", v_pdata, 0);
        chk("arst_pidx", v_pidx, 0);
        step();
        RESET = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("post_rst_idle", v_state, 0);
        chk("post_rst_erase", v_erase, 0);

        // CONVERT_CYCLES = 256, READ_CYCLES = 2
        sel = 1'b1;
        #1;
        clear_stats();
        exp_q.push_back({2'd0, 8'd255}); exp_q.push_back({2'd1, 8'd1});
        exp_q.push_back({2'd2, 8'd128}); exp_q.push_back({2'd3, 8'd0});
        START_B = 1'b1;
        step();
        START_B = 1'b0;
        chk("b_start_to_erase", v_erase, 1);
        run_to_done(700);
        chk("b_erase_len", erase_n, 5);
        check_phases(256, 2);
        chk("b_frame_len", done_cyc - first_erase, 525);
        chk("b_done_busy", done_busy, 0);
        check_pixels();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
